// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle 6502-style operations plus iterative unsigned MUL/DIV.
// MUL is shift-add and DIV is restoring division, both one bit per clock.
module alu_mc #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          DECIMAL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_flag_in,
  input  logic             D_flag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             C_flag_out,
  output logic             Z_flag_out,
  output logic             V_flag_out,
  output logic             N_flag_out
);

  localparam int unsigned Msb  = WIDTH - 1;
  localparam int unsigned Nib  = WIDTH / 4;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [3:0] OpAdd = 4'd0,  OpSub = 4'd1,  OpAnd = 4'd2,  OpOr   = 4'd3;
  localparam logic [3:0] OpXor = 4'd4,  OpInc = 4'd5,  OpDec = 4'd6,  OpPassA = 4'd7;
  localparam logic [3:0] OpPassB = 4'd8, OpAsl = 4'd9, OpLsr = 4'd10, OpRol  = 4'd11;
  localparam logic [3:0] OpRor = 4'd12, OpZero = 4'd13, OpMul = 4'd14, OpDiv = 4'd15;

  typedef enum logic [1:0] {StIdle, StIter, StFinish} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic             c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d;

  // Single-cycle datapath, fed straight from the inputs at the accepting edge
  logic [WIDTH:0]   bin_add, bin_sub;
  logic [WIDTH-1:0] dec_add, dec_sub, alu_res;
  logic [4:0]       dig;
  logic             dec_c, dec_b, dec_mode, alu_c, alu_v;

  always_comb begin
    bin_add  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C_flag_in};
    bin_sub  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, C_flag_in};
    dec_add  = '0;
    dec_sub  = '0;
    dig      = '0;
    dec_c    = C_flag_in;
    dec_b    = ~C_flag_in;
    dec_mode = DECIMAL_EN && D_flag_in;
    for (int i = 0; i < Nib; i++) begin
      dig = {1'b0, A[4*i +: 4]} + {1'b0, B[4*i +: 4]} + {4'b0, dec_c};
      if (dig > 5'd9) begin
        dig   = dig + 5'd6;
        dec_c = 1'b1;
      end else begin
        dec_c = 1'b0;
      end
      dec_add[4*i +: 4] = dig[3:0];
      // A negative digit difference wraps; subtracting 6 lands on the decimal digit
      dig = {1'b0, A[4*i +: 4]} - {1'b0, B[4*i +: 4]} - {4'b0, dec_b};
      if (dig[4]) begin
        dig   = dig - 5'd6;
        dec_b = 1'b1;
      end else begin
        dec_b = 1'b0;
      end
      dec_sub[4*i +: 4] = dig[3:0];
    end
  end

  always_comb begin
    alu_res = '0;
    alu_c   = C_flag_in;
    alu_v   = 1'b0;
    unique case (alu_op)
      OpAdd: begin
        alu_res = dec_mode ? dec_add : bin_add[WIDTH-1:0];
        alu_c   = dec_mode ? dec_c : bin_add[WIDTH];
        alu_v   = (A[Msb] == B[Msb]) && (bin_add[Msb] != A[Msb]);
      end
      OpSub: begin
        alu_res = dec_mode ? dec_sub : bin_sub[WIDTH-1:0];
        alu_c   = dec_mode ? ~dec_b : bin_sub[WIDTH];
        alu_v   = (A[Msb] != B[Msb]) && (bin_sub[Msb] != A[Msb]);
      end
      OpAnd:   alu_res = A & B;
      OpOr:    alu_res = A | B;
      OpXor:   alu_res = A ^ B;
      OpInc:   alu_res = A + 1'b1;
      OpDec:   alu_res = A - 1'b1;
      OpPassA: alu_res = A;
      OpPassB: alu_res = B;
      OpAsl: begin
        alu_res = {A[Msb-1:0], 1'b0};
        alu_c   = A[Msb];
      end
      OpLsr: begin
        alu_res = {1'b0, A[Msb:1]};
        alu_c   = A[0];
      end
      OpRol: begin
        alu_res = {A[Msb-1:0], C_flag_in};
        alu_c   = A[Msb];
      end
      OpRor: begin
        alu_res = {C_flag_in, A[Msb:1]};
        alu_c   = A[0];
      end
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {hi_q, lo_q[Msb]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_ge ? (div_sh - {1'b0, b_q}) : div_sh;
    if (op_q == OpMul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[Msb:1]};
    end else begin
      step_hi = div_diff[WIDTH-1:0];
      step_lo = {lo_q[Msb-1:0], div_ge};
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    c_d         = c_q;
    z_d         = z_q;
    v_d         = v_q;
    n_d         = n_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = alu_op;
          a_d   = A;
          b_d   = B;
          cnt_d = '0;
          hi_d  = '0;
          if (alu_op == OpMul) begin
            lo_d    = B;
            state_d = StIter;
          end else if (alu_op == OpDiv && B != '0) begin
            lo_d    = A;
            state_d = StIter;
          end else if (alu_op == OpDiv) begin
            result_d    = '1;
            result_hi_d = A;
            c_d         = 1'b0;
            z_d         = 1'b0;
            v_d         = 1'b1;
            n_d         = 1'b1;
            state_d     = StFinish;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            c_d         = alu_c;
            z_d         = (alu_res == '0);
            v_d         = alu_v;
            n_d         = alu_res[Msb];
            state_d     = StFinish;
          end
        end
      end
      StIter: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          result_d    = step_lo;
          result_hi_d = step_hi;
          c_d         = 1'b0;
          n_d         = (op_q == OpMul) ? step_hi[Msb] : step_lo[Msb];
          z_d         = (op_q == OpMul) ? ({step_hi, step_lo} == '0) : (step_lo == '0);
          v_d         = (op_q == OpMul) ? (step_hi != '0) : 1'b0;
          state_d     = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      c_q         <= c_d;
      z_q         <= z_d;
      v_q         <= v_d;
      n_q         <= n_d;
    end
  end

  assign busy       = (state_q == StIter);
  assign done       = (state_q == StFinish);
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign C_flag_out = c_q;
  assign Z_flag_out = z_q;
  assign V_flag_out = v_q;
  assign N_flag_out = n_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a WIDTH=8 and a WIDTH=16 instance, directed vectors,
// expected responses queued at issue time and checked by per-instance monitors on done.
module tb_alu_mc;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  czvn;
    int          lat;
    int          busy;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, din = 1'b0;

  logic        busy8, done8, c8, z8, v8, n8;
  logic [7:0]  res8, hi8;
  logic        busy16, done16, c16, z16, v16, n16;
  logic [15:0] res16, hi16;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_cnt8 = 0, busy_cnt16 = 0;
  exp_t q8[$];
  exp_t q16[$];

  alu_mc #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .alu_op(op), .A(a[7:0]), .B(b[7:0]),
    .C_flag_in(cin), .D_flag_in(din), .busy(busy8), .done(done8), .result(res8),
    .result_hi(hi8), .C_flag_out(c8), .Z_flag_out(z8), .V_flag_out(v8), .N_flag_out(n8)
  );

  alu_mc #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .alu_op(op), .A(a), .B(b),
    .C_flag_in(cin), .D_flag_in(din), .busy(busy16), .done(done16), .result(res16),
    .result_hi(hi16), .C_flag_out(c16), .Z_flag_out(z16), .V_flag_out(v16), .N_flag_out(n16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare(input exp_t e, input logic [15:0] r, input logic [15:0] h,
                         input logic [3:0] f, input int busy_seen);
    chk({e.name, " result"}, {16'h0, r}, {16'h0, e.res});
    chk({e.name, " result_hi"}, {16'h0, h}, {16'h0, e.hi});
    chk({e.name, " flags CZVN"}, {28'h0, f}, {28'h0, e.czvn});
    chk({e.name, " latency"}, cyc - e.acc + 1, e.lat);
    chk({e.name, " busy cycles"}, busy_seen, e.busy);
  endtask

  always @(negedge clk) begin
    if (rst) busy_cnt8 = 0;
    else if (busy8 === 1'b1) busy_cnt8++;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("w8 unexpected done", 32'd1, 32'd0);
      end else begin
        compare(q8.pop_front(), {8'h0, res8}, {8'h0, hi8}, {c8, z8, v8, n8}, busy_cnt8);
      end
      busy_cnt8 = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) busy_cnt16 = 0;
    else if (busy16 === 1'b1) busy_cnt16++;
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        chk("w16 unexpected done", 32'd1, 32'd0);
      end else begin
        compare(q16.pop_front(), res16, hi16, {c16, z16, v16, n16}, busy_cnt16);
      end
      busy_cnt16 = 0;
    end
  end

  task automatic issue(input bit w16, input string nm, input logic [3:0] o,
                       input logic [15:0] va, input logic [15:0] vb, input logic vc,
                       input logic vd, input logic [15:0] er, input logic [15:0] eh,
                       input logic [3:0] ef, input int lat, input int bsy);
    exp_t e;
    int   t;
    @(negedge clk);
    op = o; a = va; b = vb; cin = vc; din = vd;
    e.name = nm; e.res = er; e.hi = eh; e.czvn = ef; e.lat = lat; e.busy = bsy;
    e.acc = cyc + 1;
    if (w16) begin
      q16.push_back(e);
      start16 = 1'b1;
    end else begin
      q8.push_back(e);
      start8 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    t = 0;
    while ((q8.size() != 0 || q16.size() != 0) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      chk({nm, " done timeout"}, 32'd1, 32'd0);
      q8.delete();
      q16.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int dn;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset w8 outputs", {busy8, done8, c8, z8, v8, n8, res8, hi8}, 32'h0);
    chk("reset w16 result", {res16, hi16}, 32'h0);
    chk("reset w16 ctrl/flags", {26'h0, busy16, done16, c16, z16, v16, n16}, 32'h0);

    //    w16 name           op     A        B        C     D     result   hi       CZVN  lat bsy
    issue(0, "add bin",      4'd0,  16'h50,  16'h50,  1'b0, 1'b0, 16'hA0,  16'h0,   4'b0011, 1, 0);
    issue(0, "add bcd",      4'd0,  16'h58,  16'h46,  1'b1, 1'b1, 16'h05,  16'h0,   4'b1010, 1, 0);
    issue(0, "sub bcd",      4'd1,  16'h00,  16'h01,  1'b1, 1'b1, 16'h99,  16'h0,   4'b0001, 1, 0);
    issue(0, "sub bin",      4'd1,  16'h50,  16'hB0,  1'b1, 1'b0, 16'hA0,  16'h0,   4'b0011, 1, 0);
    issue(0, "and",          4'd2,  16'hF0,  16'h3C,  1'b0, 1'b0, 16'h30,  16'h0,   4'b0000, 1, 0);
    issue(0, "xor",          4'd4,  16'h5A,  16'h5A,  1'b0, 1'b0, 16'h00,  16'h0,   4'b0100, 1, 0);
    issue(0, "inc wrap",     4'd5,  16'hFF,  16'h00,  1'b0, 1'b0, 16'h00,  16'h0,   4'b0100, 1, 0);
    issue(0, "dec wrap",     4'd6,  16'h00,  16'h00,  1'b0, 1'b0, 16'hFF,  16'h0,   4'b0001, 1, 0);
    issue(0, "passb",        4'd8,  16'h11,  16'h9C,  1'b0, 1'b0, 16'h9C,  16'h0,   4'b0001, 1, 0);
    issue(0, "asl",          4'd9,  16'h80,  16'h00,  1'b0, 1'b0, 16'h00,  16'h0,   4'b1100, 1, 0);
    issue(0, "lsr",          4'd10, 16'h81,  16'h00,  1'b0, 1'b0, 16'h40,  16'h0,   4'b1000, 1, 0);
    issue(0, "rol",          4'd11, 16'h40,  16'h00,  1'b1, 1'b0, 16'h81,  16'h0,   4'b0001, 1, 0);
    issue(0, "ror",          4'd12, 16'h01,  16'h00,  1'b1, 1'b0, 16'h80,  16'h0,   4'b1001, 1, 0);
    issue(0, "zero",         4'd13, 16'h77,  16'h00,  1'b0, 1'b0, 16'h00,  16'h0,   4'b0100, 1, 0);
    issue(0, "mul zero",     4'd14, 16'h00,  16'h37,  1'b0, 1'b0, 16'h00,  16'h00,  4'b0100, 9, 8);
    issue(0, "div w8",       4'd15, 16'h64,  16'h07,  1'b0, 1'b0, 16'h0E,  16'h02,  4'b0000, 9, 8);
    issue(0, "mul ff*ff",    4'd14, 16'hFF,  16'hFF,  1'b0, 1'b0, 16'h01,  16'hFE,  4'b0011, 9, 8);

    // Abort a MUL with reset after an ignored second start
    @(negedge clk);
    op = 4'd14; a = 16'hFF; b = 16'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    op = 4'd0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort outputs cleared", {busy8, done8, c8, z8, v8, n8, res8, hi8}, 32'h0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 === 1'b1) dn++;
    end
    chk("abort no done pulse", dn, 0);
    issue(0, "add after abort", 4'd0, 16'h50, 16'h50, 1'b0, 1'b0, 16'hA0, 16'h0, 4'b0011, 1, 0);

    issue(1, "div w16",      4'd15, 16'h1234, 16'h0010, 1'b0, 1'b0, 16'h0123, 16'h0004, 4'b0000, 17, 16);
    issue(1, "div by zero",  4'd15, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16'h1234, 4'b0011, 1, 0);
    issue(1, "add bcd w16",  4'd0,  16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'b1100, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width; legal values are multiples of 4 and at least 8.
REQ-002 SHALL provide parameter DECIMAL_EN, default 1, which when 1 enables BCD correction for ADD/SUB.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  request pulse; sampled only in IDLE.
REQ-007 alu_op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 DEC, 7 PASSA, 8 PASSB, 9 ASL, 10 LSR, 11 ROL, 12 ROR, 13 ZERO, 14 MUL, 15 DIV.
REQ-008 A, B  in  WIDTH  operands.
REQ-009 C_flag_in  in  1  carry in.
REQ-010 D_flag_in  in  1  decimal mode for ADD/SUB.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 result  out  WIDTH  primary result (MUL low half, DIV quotient).
REQ-014 result_hi  out  WIDTH  MUL high half, DIV remainder, 0 otherwise.
REQ-015 C_flag_out, Z_flag_out, V_flag_out, N_flag_out  out  1 each  registered flags.

Function
REQ-016 SHALL latch A, B, alu_op, C_flag_in, D_flag_in when start=1 in IDLE; inputs are ignored at all other times.
REQ-017 SHALL implement FSM states IDLE, ITER, FINISH: IDLE->FINISH on start with ops 0-13 or DIV with B=0; IDLE->ITER on start with MUL/DIV; ITER->FINISH after WIDTH iterations; FINISH->IDLE unconditionally.
REQ-018 SHALL assert done for exactly the one FINISH cycle; outputs update in that cycle and hold until the next FINISH.
REQ-019 Latency: ops 0-13 done in cycle k+1 after start accepted at edge k; MUL/DIV done in cycle k+WIDTH+1.
REQ-020 start while busy or done SHALL be ignored and not queued.
REQ-021 Ops 0-13 SHALL match the single-cycle 6502 ALU semantics, generalised to WIDTH: ADD carry/overflow, SUB with borrow = ~C_flag_in and C = no-borrow, shifts/rotates through carry from the MSB/LSB.
REQ-022 ADD/SUB with D_flag_in=1 and DECIMAL_EN=1 SHALL apply per-nibble BCD correction (+6/-6) across all WIDTH/4 digits; C = decimal carry/no-borrow; V from the binary sum; N, Z from the corrected result.
REQ-023 MUL SHALL be unsigned shift-add, one bit per cycle; {result_hi,result}=A*B; Z=(2*WIDTH product==0); N=result_hi MSB; V=(result_hi!=0); C=0.
REQ-024 DIV SHALL be unsigned restoring division, one bit per cycle; result=A/B, result_hi=A%B; Z=(quotient==0); N=quotient MSB; V=0; C=0.
REQ-025 DIV with B=0 SHALL complete in cycle k+1 with result all-ones, result_hi=A, V=1, C=0, Z=0, N=1.
REQ-026 For ops 0-13, Z=(result==0), N=result MSB, and result_hi=0.

Reset
REQ-027 rst SHALL force IDLE and clear busy, done, result, result_hi and all flags to 0 on the next edge.
REQ-028 rst during ITER or FINISH SHALL abort the operation with no done pulse; rst has priority over start in the same cycle.

Verification
REQ-029 WIDTH=8, ADD A=0x50 B=0x50 C=0 D=0 -> one cycle later done=1, result=0xA0, V=1, N=1, C=0, Z=0.
REQ-030 WIDTH=8, ADD A=0x58 B=0x46 C=1 D=1 -> result=0x05, C=1; SUB A=0x00 B=0x01 C=1 D=1 -> result=0x99, C=0.
REQ-031 WIDTH=8, MUL A=0xFF B=0xFF -> done exactly 9 cycles after start edge, result=0x01, result_hi=0xFE, V=1, busy high for 8 cycles.
REQ-032 WIDTH=16, DIV A=0x1234 B=0x0010 -> done at cycle 17, result=0x0123, result_hi=0x0004; DIV B=0 -> done at cycle 1, result=0xFFFF, result_hi=0x1234, V=1.
REQ-033 Start MUL, pulse start again at cycle 3 and assert rst at cycle 5 -> second start ignored, no done pulse, all outputs 0, next start accepted normally.
REQ-034 ROR A=0x01 C=1 -> result=0x80, C=1, N=1; ASL A=0x80 -> result=0x00, C=1, Z=1.
